// File: rtl/axi_throughput_meter.sv
`default_nettype none
// ============================================================================
// Module : axi_throughput_meter
// Brief  : Per-port AXI handshake counters over a programmable cycle window,
//          latched into a snapshot bank readable while the next window runs.
// Rev    : 1.0  initial release
// ============================================================================
module axi_throughput_meter #(
    parameter int N_PORTS = 16,
    parameter int CNT_W   = 32,
    parameter int WIN_W   = 24,
    parameter int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [N_PORTS-1:0] awvalid,
    input  logic [N_PORTS-1:0] awready,
    input  logic [N_PORTS-1:0] wvalid,
    input  logic [N_PORTS-1:0] wready,
    input  logic [N_PORTS-1:0] bvalid,
    input  logic [N_PORTS-1:0] bready,
    input  logic [N_PORTS-1:0] arvalid,
    input  logic [N_PORTS-1:0] arready,
    input  logic [N_PORTS-1:0] rvalid,
    input  logic [N_PORTS-1:0] rready,
    input  logic [N_PORTS-1:0] rlast,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [WIN_W-1:0]   window_len,
    output logic               busy,
    output logic               done,
    input  logic [IDX_W-1:0]   rd_port,
    input  logic [2:0]         rd_sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic               rd_sat
);

    localparam int c_NUM_CH = 6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic                w_start_ok;
    logic                w_win_end;
    logic                r_done;
    logic [WIN_W-1:0]    r_win_cnt;
    logic [WIN_W-1:0]    r_win_len;
    logic [WIN_W-1:0]    r_snap_cyc;
    logic [CNT_W-1:0]    w_cyc;

    logic [CNT_W-1:0]    r_live     [N_PORTS][c_NUM_CH];
    logic [CNT_W-1:0]    r_snap     [N_PORTS][c_NUM_CH];
    logic [CNT_W-1:0]    w_inc      [N_PORTS][c_NUM_CH];
    logic [c_NUM_CH-1:0] r_live_sat [N_PORTS];
    logic [c_NUM_CH-1:0] r_snap_sat [N_PORTS];
    logic [c_NUM_CH-1:0] w_ev       [N_PORTS];
    logic [c_NUM_CH-1:0] w_hit_max  [N_PORTS];

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // stop outranks a window end landing in the same cycle
    always_comb begin
        w_state_nx = r_state;
        w_start_ok = 1'b0;
        w_win_end  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (window_len != '0)) begin
                    w_start_ok = 1'b1;
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nx = S_IDLE;
                end else if (r_win_cnt == WIN_W'(1)) begin
                    w_win_end = 1'b1;
                    if (!cont) begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Channel order matches rd_sel encoding 0..5
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            w_ev[p] = {rvalid[p] & rready[p] & rlast[p],
                       rvalid[p] & rready[p],
                       arvalid[p] & arready[p],
                       bvalid[p] & bready[p],
                       wvalid[p] & wready[p],
                       awvalid[p] & awready[p]};
            for (int c = 0; c < c_NUM_CH; c++) begin
                w_hit_max[p][c] = w_ev[p][c] & (&r_live[p][c]);
                w_inc[p][c]     = (w_ev[p][c] && !w_hit_max[p][c]) ?
                                  r_live[p][c] + CNT_W'(1) : r_live[p][c];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_done     <= 1'b0;
            r_win_cnt  <= '0;
            r_win_len  <= '0;
            r_snap_cyc <= '0;
            for (int p = 0; p < N_PORTS; p++) begin
                r_live_sat[p] <= '0;
                r_snap_sat[p] <= '0;
                for (int c = 0; c < c_NUM_CH; c++) begin
                    r_live[p][c] <= '0;
                    r_snap[p][c] <= '0;
                end
            end
        end else begin
            r_done <= w_win_end;

            if (w_start_ok) begin
                r_win_len <= window_len;
                r_win_cnt <= window_len;
            end else if (w_win_end) begin
                r_win_cnt <= r_win_len;
            end else if (r_state == S_RUN) begin
                r_win_cnt <= r_win_cnt - WIN_W'(1);
            end

            // Snapshot includes the increments of the final counted cycle
            if (w_win_end) begin
                r_snap_cyc <= r_win_len;
                for (int p = 0; p < N_PORTS; p++) begin
                    r_snap_sat[p] <= r_live_sat[p] | w_hit_max[p];
                    for (int c = 0; c < c_NUM_CH; c++) begin
                        r_snap[p][c] <= w_inc[p][c];
                    end
                end
            end

            for (int p = 0; p < N_PORTS; p++) begin
                if (w_start_ok || w_win_end) begin
                    r_live_sat[p] <= '0;
                    for (int c = 0; c < c_NUM_CH; c++) begin
                        r_live[p][c] <= '0;
                    end
                end else if (r_state == S_RUN) begin
                    r_live_sat[p] <= r_live_sat[p] | w_hit_max[p];
                    for (int c = 0; c < c_NUM_CH; c++) begin
                        r_live[p][c] <= w_inc[p][c];
                    end
                end
            end
        end
    end

    // Window length clips to the counter maximum when it cannot fit
    generate
        if (WIN_W > CNT_W) begin : g_cyc_clip
            assign w_cyc = (|r_snap_cyc[WIN_W-1:CNT_W]) ? '1 : r_snap_cyc[CNT_W-1:0];
        end else begin : g_cyc_ext
            assign w_cyc = CNT_W'(r_snap_cyc);
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        rd_sat  = 1'b0;
        if (int'(rd_port) < N_PORTS) begin
            if (rd_sel < 3'd6) begin
                rd_data = r_snap[rd_port][rd_sel];
                rd_sat  = r_snap_sat[rd_port][rd_sel];
            end else if (rd_sel == 3'd6) begin
                rd_data = w_cyc;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_axi_throughput_meter.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_throughput_meter
// Brief  : Randomized windows checked against a per-window handshake tally.
// Rev    : 1.0  initial release
// ============================================================================
module tb_axi_throughput_meter;

    localparam int NP   = 5;
    localparam int CW   = 5;
    localparam int WW   = 6;
    localparam int IW   = 3;
    localparam int NCH  = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          aclk = 1'b0;
    logic          areset;
    logic [NP-1:0] awvalid, awready, wvalid, wready, bvalid, bready;
    logic [NP-1:0] arvalid, arready, rvalid, rready, rlast;
    logic          start, stop, cont;
    logic [WW-1:0] window_len;
    logic          busy, done;
    logic [IW-1:0] rd_port;
    logic [2:0]    rd_sel;
    logic [CW-1:0] rd_data;
    logic          rd_sat;

    axi_throughput_meter #(
        .N_PORTS(NP), .CNT_W(CW), .WIN_W(WW), .IDX_W(IW)
    ) dut (
        .aclk(aclk), .areset(areset),
        .awvalid(awvalid), .awready(awready), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready), .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .start(start), .stop(stop), .cont(cont), .window_len(window_len),
        .busy(busy), .done(done),
        .rd_port(rd_port), .rd_sel(rd_sel), .rd_data(rd_data), .rd_sat(rd_sat)
    );

    always #100 aclk = ~aclk;

    int vectors = 0;
    int errors  = 0;
    int acc  [NP][NCH];   // handshakes seen in the window being counted
    int snap [NP][NCH];   // what the last completed window should report
    int snap_w;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_acc();
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < NCH; c++)
                acc[p][c] = 0;
    endtask

    function automatic logic rnd(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic drive(input int pct, input bit counted);
        for (int p = 0; p < NP; p++) begin
            awvalid[p] = rnd(pct); awready[p] = rnd(pct);
            wvalid[p]  = rnd(pct); wready[p]  = rnd(pct);
            bvalid[p]  = rnd(pct); bready[p]  = rnd(pct);
            arvalid[p] = rnd(pct); arready[p] = rnd(pct);
            rvalid[p]  = rnd(pct); rready[p]  = rnd(pct);
            rlast[p]   = rnd(50);
            if (counted) begin
                if (awvalid[p] && awready[p]) acc[p][0]++;
                if (wvalid[p] && wready[p])   acc[p][1]++;
                if (bvalid[p] && bready[p])   acc[p][2]++;
                if (arvalid[p] && arready[p]) acc[p][3]++;
                if (rvalid[p] && rready[p])   acc[p][4]++;
                if (rvalid[p] && rready[p] && rlast[p]) acc[p][5]++;
            end
        end
    endtask

    task automatic check_readout(input string tag);
        for (int p = 0; p < 8; p++) begin
            for (int s = 0; s < 8; s++) begin
                rd_port = IW'(p);
                rd_sel  = 3'(s);
                #1;
                if (p >= NP || s == 7) begin
                    check($sformatf("%s_p%0d_s%0d_data", tag, p, s), 32'(rd_data), 0);
                    check($sformatf("%s_p%0d_s%0d_sat", tag, p, s), 32'(rd_sat), 0);
                end else if (s == 6) begin
                    if (snap_w <= CMAX)
                        check($sformatf("%s_p%0d_cycles", tag, p), 32'(rd_data), snap_w);
                end else begin
                    check($sformatf("%s_p%0d_s%0d_data", tag, p, s), 32'(rd_data),
                          (snap[p][s] > CMAX) ? CMAX : snap[p][s]);
                    check($sformatf("%s_p%0d_s%0d_sat", tag, p, s), 32'(rd_sat),
                          32'(snap[p][s] > CMAX));
                end
            end
        end
    endtask

    // One measurement of nwin back-to-back windows; stop_k>0 aborts in window 1
    task automatic run(input int w, input int nwin, input int pct, input int stop_k);
        clear_acc();
        start = 1'b1; window_len = WW'(w); cont = (nwin > 1); stop = 1'b0;
        drive(pct, 1'b0);
        tick();
        for (int j = 1; j <= nwin; j++) begin
            for (int k = 1; k <= w; k++) begin
                check("busy_run", 32'(busy), 1);
                check("done_run", 32'(done), 32'(j > 1 && k == 1));
                if (j > 1 && k == 1) check_readout("cont");
                drive(pct, 1'b1);
                start      = rnd(10);
                window_len = WW'($urandom_range(63));
                cont       = (k == w) ? (j < nwin) : 1'($urandom_range(1));
                stop       = (j == 1 && k == stop_k);
                tick();
                if (stop) begin
                    stop = 1'b0; start = 1'b0; cont = 1'b0;
                    check("busy_after_stop", 32'(busy), 0);
                    check("done_after_stop", 32'(done), 0);
                    check_readout("stop");
                    tick();
                    check("done_stop_later", 32'(done), 0);
                    return;
                end
            end
            snap   = acc;
            snap_w = w;
            clear_acc();
        end
        start = 1'b0; cont = 1'b0;
        check("done_end", 32'(done), 1);
        check("busy_end", 32'(busy), 0);
        check_readout("end");
        tick();
        check("done_pulse", 32'(done), 0);
        check("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        areset = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; window_len = '0;
        rd_port = '0; rd_sel = '0;
        drive(0, 1'b0);
        clear_acc();
        snap   = acc;
        snap_w = 0;
        repeat (3) tick();
        areset = 1'b0;
        tick();
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check_readout("reset");

        run(10, 1, 100, 0);
        run(16, 1, 50, 0);
        run(8, 4, 60, 0);
        run(1, 1, 70, 0);
        run(1, 3, 70, 0);
        run(40, 1, 100, 0);
        run(12, 2, 30, 0);
        run(10, 1, 50, 5);
        run(10, 1, 50, 10);

        start = 1'b1; window_len = '0;
        tick();
        start = 1'b0;
        check("zero_len_busy", 32'(busy), 0);
        tick();
        check("zero_len_done", 32'(done), 0);
        check_readout("zero_len");

        for (int i = 0; i < 8; i++) begin
            int w;
            w = int'($urandom_range(40, 1));
            run(w, int'($urandom_range(3, 1)), int'($urandom_range(100, 20)),
                rnd(30) ? int'($urandom_range(w, 1)) : 0);
        end

        start = 1'b1; window_len = WW'(20); cont = 1'b1;
        drive(80, 1'b0);
        tick();
        start = 1'b0;
        repeat (5) begin
            drive(80, 1'b0);
            tick();
        end
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check("mid_reset_busy", 32'(busy), 0);
        check("mid_reset_done", 32'(done), 0);
        clear_acc();
        snap   = acc;
        snap_w = 0;
        check_readout("mid_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
